// File: rtl/pll_search_pkg.sv
// Shared iCE40 PLL limits, coefficient widths and solver FSM encoding.
package pll_search_pkg;

  localparam int unsigned DivrW = 4;
  localparam int unsigned DivfW = 7;
  localparam int unsigned DivqW = 3;

  localparam int unsigned PfdMinHz = 10_000_000;
  localparam int unsigned PfdMaxHz = 133_000_000;
  localparam int unsigned VcoMinHz = 533_000_000;
  localparam int unsigned VcoMaxHz = 1_066_000_000;

  typedef enum logic [2:0] {
    StIdle,
    StDiv,
    StChkPfd,
    StSweep,
    StNextR,
    StFin
  } state_e;

  // Simple feedback allows the full 7-bit DIVF range; the other modes are limited to 6 bits.
  function automatic int unsigned divf_max(input bit simple_feedback);
    return simple_feedback ? 127 : 63;
  endfunction

endpackage

// File: rtl/pll_udiv.sv
// Restoring serial unsigned divider: one quotient bit per cycle, WIDTH cycles per division.
module pll_udiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_sh;

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    if (cnt_q == '0) begin
      if (start) begin
        cnt_d = CntW'(WIDTH);
        rem_d = '0;
        quo_d = dividend;
        dvs_d = divisor;
      end
    end else begin
      cnt_d = cnt_q - CntW'(1);
      if (rem_sh >= {1'b0, dvs_q}) begin
        // Remainder stays below the divisor, so the low WIDTH bits hold the exact difference.
        rem_d = rem_sh[WIDTH-1:0] - dvs_q;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign done     = (cnt_q == CntW'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/pll_param_search.sv
// Runtime iCE40 PLL coefficient solver sweeping DIVR/DIVF/DIVQ for the closest output frequency.
// Define PLL_SEARCH_EXACT_EXIT_EN to stop the sweep at the first zero-error candidate.
module pll_param_search
  import pll_search_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter bit          SIMPLE_FEEDBACK = 1'b1,
  parameter int unsigned DIVR_MAX        = 15,
  parameter int unsigned DIVQ_MIN        = 1,
  parameter int unsigned DIVQ_MAX        = 6,
  parameter int unsigned F_PFD_MIN       = PfdMinHz,
  parameter int unsigned F_PFD_MAX       = PfdMaxHz,
  parameter int unsigned F_VCO_MIN       = VcoMinHz,
  parameter int unsigned F_VCO_MAX       = VcoMaxHz
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] f_in,
  input  logic [WIDTH-1:0] f_target,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] best_fout,
  output logic [WIDTH-1:0] best_err,
  output logic [DivrW-1:0] best_divr,
  output logic [DivfW-1:0] best_divf,
  output logic [DivqW-1:0] best_divq
);

  localparam logic [DivrW-1:0] DivrMax = DivrW'(DIVR_MAX);
  localparam logic [DivfW-1:0] DivfMax = DivfW'(divf_max(SIMPLE_FEEDBACK));
  localparam logic [DivqW-1:0] DivqMin = DivqW'(DIVQ_MIN);
  localparam logic [DivqW-1:0] DivqMax = DivqW'(DIVQ_MAX);
  localparam logic [WIDTH-1:0] PfdMin  = WIDTH'(F_PFD_MIN);
  localparam logic [WIDTH-1:0] PfdMax  = WIDTH'(F_PFD_MAX);
  localparam logic [WIDTH:0]   VcoMin  = (WIDTH + 1)'(F_VCO_MIN);
  localparam logic [WIDTH:0]   VcoMax  = (WIDTH + 1)'(F_VCO_MAX);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] f_in_q, f_in_d;
  logic [WIDTH-1:0] f_tgt_q, f_tgt_d;
  logic [DivrW-1:0] divr_q, divr_d;
  logic [DivfW-1:0] divf_q, divf_d;
  logic [DivqW-1:0] divq_q, divq_d;
  logic [WIDTH:0]   f_vco_q, f_vco_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] best_fout_q, best_fout_d;
  logic [WIDTH-1:0] best_err_q, best_err_d;
  logic [DivrW-1:0] best_divr_q, best_divr_d;
  logic [DivfW-1:0] best_divf_q, best_divf_d;
  logic [DivqW-1:0] best_divq_q, best_divq_d;

  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_dividend, div_divisor, f_pfd;
  logic [WIDTH-1:0] fout, err;
  logic             vco_low, vco_high, step_f;

  // The first division is launched in the same cycle the request is accepted.
  assign div_dividend = (state_q == StIdle) ? f_in : f_in_q;
  assign div_divisor  = WIDTH'({1'b0, divr_d}) + WIDTH'(1);

  pll_udiv #(
    .WIDTH(WIDTH)
  ) u_udiv (
    .CLK     (CLK),
    .reset   (reset),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(f_pfd)
  );

  always_comb begin
    state_d     = state_q;
    f_in_d      = f_in_q;
    f_tgt_d     = f_tgt_q;
    divr_d      = divr_q;
    divf_d      = divf_q;
    divq_d      = divq_q;
    f_vco_d     = f_vco_q;
    found_d     = found_q;
    best_fout_d = best_fout_q;
    best_err_d  = best_err_q;
    best_divr_d = best_divr_q;
    best_divf_d = best_divf_q;
    best_divq_d = best_divq_q;
    div_start   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    step_f      = 1'b0;
    fout        = WIDTH'(f_vco_q >> divq_q);
    err         = (fout >= f_tgt_q) ? (fout - f_tgt_q) : (f_tgt_q - fout);
    vco_low     = (f_vco_q < VcoMin);
    vco_high    = (f_vco_q > VcoMax);

    unique case (state_q)
      StIdle: begin
        if (start && !div_busy) begin
          f_in_d      = f_in;
          f_tgt_d     = f_target;
          divr_d      = '0;
          found_d     = 1'b0;
          best_fout_d = '0;
          best_err_d  = '0;
          best_divr_d = '0;
          best_divf_d = '0;
          best_divq_d = '0;
          div_start   = 1'b1;
          state_d     = StDiv;
        end
      end
      StDiv: begin
        busy = 1'b1;
        if (div_done) state_d = StChkPfd;
      end
      StChkPfd: begin
        busy = 1'b1;
        if (f_pfd < PfdMin || f_pfd > PfdMax) begin
          state_d = StNextR;
        end else begin
          divf_d  = '0;
          f_vco_d = {1'b0, f_pfd};
          divq_d  = DivqMin;
          state_d = StSweep;
        end
      end
      StSweep: begin
        busy = 1'b1;
        // VCO only grows with DIVF, so overshooting the window ends this DIVR.
        if (vco_high) begin
          state_d = StNextR;
        end else begin
          if (!vco_low && (!found_q || err < best_err_q)) begin
            found_d     = 1'b1;
            best_fout_d = fout;
            best_err_d  = err;
            best_divr_d = divr_q;
            best_divf_d = divf_q;
            best_divq_d = divq_q;
          end
          step_f = vco_low || (divq_q == DivqMax);
          if (!step_f) begin
            divq_d = divq_q + DivqW'(1);
          end else if (divf_q == DivfMax) begin
            state_d = StNextR;
          end else begin
            divf_d  = divf_q + DivfW'(1);
            f_vco_d = f_vco_q + {1'b0, f_pfd};
            divq_d  = DivqMin;
          end
`ifdef PLL_SEARCH_EXACT_EXIT_EN
          if (!vco_low && err == '0) state_d = StFin;
`else
`endif
        end
      end
      StNextR: begin
        busy = 1'b1;
        if (divr_q == DivrMax) begin
          state_d = StFin;
        end else begin
          divr_d    = divr_q + DivrW'(1);
          div_start = 1'b1;
          state_d   = StDiv;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      f_in_q      <= '0;
      f_tgt_q     <= '0;
      divr_q      <= '0;
      divf_q      <= '0;
      divq_q      <= '0;
      f_vco_q     <= '0;
      found_q     <= 1'b0;
      best_fout_q <= '0;
      best_err_q  <= '0;
      best_divr_q <= '0;
      best_divf_q <= '0;
      best_divq_q <= '0;
    end else begin
      state_q     <= state_d;
      f_in_q      <= f_in_d;
      f_tgt_q     <= f_tgt_d;
      divr_q      <= divr_d;
      divf_q      <= divf_d;
      divq_q      <= divq_d;
      f_vco_q     <= f_vco_d;
      found_q     <= found_d;
      best_fout_q <= best_fout_d;
      best_err_q  <= best_err_d;
      best_divr_q <= best_divr_d;
      best_divf_q <= best_divf_d;
      best_divq_q <= best_divq_d;
    end
  end

  assign found     = found_q;
  assign best_fout = best_fout_q;
  assign best_err  = best_err_q;
  assign best_divr = best_divr_q;
  assign best_divf = best_divf_q;
  assign best_divq = best_divq_q;

endmodule

// File: tb/tb_pll_param_search.sv
// Directed bench for pll_param_search: hand-computed cases, control corner cases, model-checked random pairs.
module tb_pll_param_search;

  localparam int Limit = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_nf = 1'b0;
  logic [31:0] f_in = '0;
  logic [31:0] f_target = '0;

  logic        busy, done, found;
  logic [31:0] best_fout, best_err;
  logic [3:0]  best_divr;
  logic [6:0]  best_divf;
  logic [2:0]  best_divq;

  logic        busy_nf, done_nf, found_nf;
  logic [31:0] best_fout_nf, best_err_nf;
  logic [3:0]  best_divr_nf;
  logic [6:0]  best_divf_nf;
  logic [2:0]  best_divq_nf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pll_param_search dut (
    .CLK      (clk),
    .reset    (rst),
    .start    (start),
    .f_in     (f_in),
    .f_target (f_target),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .best_fout(best_fout),
    .best_err (best_err),
    .best_divr(best_divr),
    .best_divf(best_divf),
    .best_divq(best_divq)
  );

  pll_param_search #(
    .SIMPLE_FEEDBACK(1'b0)
  ) dut_nf (
    .CLK      (clk),
    .reset    (rst),
    .start    (start_nf),
    .f_in     (f_in),
    .f_target (f_target),
    .busy     (busy_nf),
    .done     (done_nf),
    .found    (found_nf),
    .best_fout(best_fout_nf),
    .best_err (best_err_nf),
    .best_divr(best_divr_nf),
    .best_divf(best_divf_nf),
    .best_divq(best_divq_nf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] fi, input logic [31:0] ft);
    @(negedge clk);
    f_in     = fi;
    f_target = ft;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (done !== 1'b1 && cyc < Limit) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic fnd, input logic [31:0] fo,
                              input logic [31:0] er, input int r, input int f, input int q);
    check({tag, "_found"}, 64'(found), 64'(fnd));
    check({tag, "_fout"}, 64'(best_fout), 64'(fo));
    check({tag, "_err"}, 64'(best_err), 64'(er));
    check({tag, "_divr"}, 64'(best_divr), 64'(r));
    check({tag, "_divf"}, 64'(best_divf), 64'(f));
    check({tag, "_divq"}, 64'(best_divq), 64'(q));
  endtask

  task automatic run_case(input string tag, input logic [31:0] fi, input logic [31:0] ft,
                          input logic fnd, input logic [31:0] fo, input logic [31:0] er,
                          input int r, input int f, input int q);
    start_job(fi, ft);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(tag);
    check_result(tag, fnd, fo, er, r, f, q);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Plain nested-loop sweep in the solver's order with the same truncating PFD divide.
  task automatic model(input longint fi, input longint ft, input int dmax, output logic fnd,
                       output longint bf, output longint be, output int br, output int bff,
                       output int bq);
    longint pfd, vco, fo, er;
    fnd = 1'b0; bf = 0; be = 0; br = 0; bff = 0; bq = 0;
    for (int r = 0; r <= 15; r++) begin
      pfd = fi / (r + 1);
      if (pfd < 10_000_000 || pfd > 133_000_000) continue;
      for (int f = 0; f <= dmax; f++) begin
        vco = pfd * (f + 1);
        if (vco > 1_066_000_000) break;
        if (vco < 533_000_000) continue;
        for (int q = 1; q <= 6; q++) begin
          fo = vco >> q;
          er = (fo >= ft) ? fo - ft : ft - fo;
          if (!fnd || er < be) begin
            fnd = 1'b1; bf = fo; be = er; br = r; bff = f; bq = q;
          end
        end
      end
    end
  endtask

  initial begin
    logic   m_fnd;
    longint m_fo, m_er, fi, ft;
    int     m_r, m_f, m_q, n_done;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_found", 64'(found), 64'd0);
    check("rst_fout", 64'(best_fout), 64'd0);
    check("rst_divf", 64'(best_divf), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_case("c16_100", 32'd16_000_000, 32'd100_000_000, 1'b1, 32'd100_000_000, 32'd0, 0, 49, 3);
    repeat (5) @(negedge clk);
    check("hold_fout", 64'(best_fout), 64'd100_000_000);
    run_case("c12_48", 32'd12_000_000, 32'd48_000_000, 1'b1, 32'd48_000_000, 32'd0, 0, 63, 4);
    run_case("c12_100", 32'd12_000_000, 32'd100_000_000, 1'b1, 32'd100_500_000, 32'd500_000,
             0, 66, 3);
    run_case("c5", 32'd5_000_000, 32'd100_000_000, 1'b0, 32'd0, 32'd0, 0, 0, 0);
    run_case("c0", 32'd0, 32'd48_000_000, 1'b0, 32'd0, 32'd0, 0, 0, 0);

    // Non-simple feedback caps DIVF at 63, so 12 MHz can only reach 96 MHz near 100 MHz.
    @(negedge clk);
    f_in = 32'd12_000_000; f_target = 32'd100_000_000; start_nf = 1'b1;
    @(negedge clk);
    start_nf = 1'b0;
    n_done = 0;
    while (done_nf !== 1'b1 && n_done < Limit) begin
      @(negedge clk);
      n_done++;
    end
    check("nf_done", 64'(done_nf), 64'd1);
    check("nf_found", 64'(found_nf), 64'd1);
    check("nf_fout", 64'(best_fout_nf), 64'd96_000_000);
    check("nf_err", 64'(best_err_nf), 64'd4_000_000);
    check("nf_divr", 64'(best_divr_nf), 64'd0);
    check("nf_divf", 64'(best_divf_nf), 64'd63);
    check("nf_divq", 64'(best_divq_nf), 64'd3);

    // A second start while busy must not restart or retarget the search.
    start_job(32'd16_000_000, 32'd100_000_000);
    repeat (50) @(negedge clk);
    f_in = 32'd12_000_000; f_target = 32'd48_000_000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("midstart");
    check_result("midstart", 1'b1, 32'd100_000_000, 32'd0, 0, 49, 3);

    // Reset in the middle of a search clears everything and suppresses done.
    @(negedge clk);
    start_job(32'd16_000_000, 32'd100_000_000);
    repeat (100) @(negedge clk);
    check("pre_rst_found", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_found", 64'(found), 64'd0);
    check("midrst_fout", 64'(best_fout), 64'd0);
    check("midrst_divf", 64'(best_divf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'd0);
    run_case("after_rst", 32'd12_000_000, 32'd48_000_000, 1'b1, 32'd48_000_000, 32'd0, 0, 63, 4);

    for (int k = 0; k < 4; k++) begin
      fi = longint'($urandom_range(133_000_000, 10_000_000));
      ft = longint'($urandom_range(275_000_000, 16_000_000));
      model(fi, ft, 127, m_fnd, m_fo, m_er, m_r, m_f, m_q);
      run_case($sformatf("rnd%0d", k), 32'(fi), 32'(ft), m_fnd, 32'(m_fo), 32'(m_er),
               m_r, m_f, m_q);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
